gpr_ctx_seq: RTL and testbench
==============================

GPR_CTX_SEQ -- requirements
Module: gpr_ctx_seq

Interface
REQ-001 SHALL have these ports, with clock and reset first:
- clock  in  1  sole clock, all state rises on posedge.
- reset  in  1  asynchronous, active-low; 0 = reset.
- ctxReq  in  1  start pulse; sampled only in IDLE.
- ctxDir  in  1  0 = save (regs to mem), 1 = restore (mem to regs).
- ctxBase  in  48  memory base byte address.
- ctxBusy  out  1  1 while not IDLE.
- ctxDone  out  1  one-cycle pulse on successful completion.
- ctxErr  out  1  one-cycle pulse on misalignment or memory error.
- seqHold  out  1  pipeline hold to the GPR file; equals ctxBusy.
- seqIdRm  out  6  register read ID driven into the GPR Rm port.
- seqValRm  in  64  GPR Rm read value, combinational.
- seqIdRn  out  6  register write ID, applied at the EX3 write slot.
- seqValRn  out  64  register write value.
- memReq  out  1  memory request, held until memOk or memErr.
- memWr  out  1  1 = store, 0 = load.
- memAddr  out  48  memory address.
- memDataOut  out  64  store data.
- memDataIn  in  64  load data, valid with memOk.
- memOk  in  1  request complete.
- memErr  in  1  request failed.

Function
REQ-002 Slot list is 35 entries, idx 0..34: 0..31 map to ID {0,idx[4:0]}; 32 maps to JX2_GR_DLR; 33 to JX2_GR_DHR; 34 to JX2_GR_SP.
REQ-003 memAddr SHALL be ctxBase + idx*8, computed as a 48-bit sum that wraps modulo 2^48.
REQ-004 FSM states SHALL be IDLE, SV_RD, SV_WR, RS_RD, RS_WR, FIN, ERR.
REQ-005 IDLE transitions on ctxReq=1:
- ctxBase[2:0]!=0: go to ERR with no memory traffic.
- otherwise idx=0, then SV_RD if ctxDir=0, RS_RD if ctxDir=1.
REQ-006 SV_RD: drive seqIdRm=slot ID, latch seqValRm into the data register, go to SV_WR; exactly 1 cycle.
REQ-007 SV_WR: memReq=1, memWr=1, memDataOut=latched value.
- on memOk: idx==34 goes to FIN, else idx+1 and back to SV_RD.
REQ-008 RS_RD: memReq=1, memWr=0; on memOk latch memDataIn and go to RS_WR.
REQ-009 RS_WR: drive seqIdRn=slot ID and seqValRn=latched data for exactly 1 cycle.
- idx==34 goes to FIN, else idx+1 and back to RS_RD.
REQ-010 memErr in SV_WR or RS_RD SHALL go to ERR.
- memErr takes priority over a simultaneous memOk.
- Registers already restored are left modified.
REQ-011 FIN pulses ctxDone for 1 cycle; ERR pulses ctxErr for 1 cycle; both then return to IDLE.
REQ-012 Outside RS_WR, seqIdRn SHALL be JX2_GR_ZZR so no GPR write occurs; outside SV_RD, seqIdRm SHALL be JX2_GR_ZZR.
REQ-013 memReq, memAddr, memWr and memDataOut SHALL stay stable from assertion until memOk or memErr.
REQ-014 ctxReq while ctxBusy=1 SHALL be ignored and SHALL NOT be queued.
REQ-015 With zero-wait memory (memOk in the first request cycle), a full pass SHALL take 70 cycles plus FIN.
- ctxDone rises in cycle 72 after the ctxReq sample.

Reset
REQ-016 reset=0 SHALL force these values:
- state=IDLE, idx=0, data register=0.
- ctxBusy, ctxDone, ctxErr, seqHold, memReq, memWr = 0.
- memAddr=0, memDataOut=0, seqValRn=0.
- seqIdRm = seqIdRn = JX2_GR_ZZR.
REQ-017 Reset asserted mid-operation SHALL abort immediately, with no ctxDone or ctxErr pulse; the memory side SHALL tolerate the dropped memReq.

Structure
REQ-018 The shared JX2 package SHALL hold:
- JX2_GR_DLR, JX2_GR_DHR, JX2_GR_SP, JX2_GR_ZZR.
- the FSM state encodings.
- the slot count, 35.
REQ-019 One sub-module, gpr_ctx_slotmap, SHALL hold the combinational map idx to register ID; all other logic is flat.

Verification
REQ-020 Save, zero-wait memory:
- stimulus: GPR i = 0x1000+i, DLR=0xAA, DHR=0xBB, SP=0xCC; ctxBase=0x4000, ctxDir=0.
- response: 35 stores to 0x4000..0x4110 with matching data; ctxDone in cycle 72; seqHold high throughout.
REQ-021 Restore, 2-wait-state memory:
- stimulus: memory holds pattern 0xDEAD0000+idx.
- response: 35 seqIdRn writes in slot order with correct values; ctxDone once.
REQ-022 Misalignment:
- stimulus: ctxBase=0x4004.
- response: ctxErr pulse 2 cycles after ctxReq; memReq never asserted; no GPR write.
REQ-023 Memory error:
- stimulus: memErr together with memOk on slot 5 during restore.
- response: ctxErr pulse; slots 0..4 written, slot 5 onward untouched; return to IDLE.
REQ-024 Reset and re-request:
- stimulus: reset=0 during SV_WR of slot 10, then release.
- response: all outputs at reset values; a second ctxReq while busy is ignored; a new save then completes normally.

Source files
------------

// File: rtl/gpr_ctx_seq_pkg.sv
// Shared JX2 definitions used by the GPR context save/restore sequencer.
package gpr_ctx_seq_pkg;

  localparam logic [5:0] JX2_GR_DLR = 6'h20;
  localparam logic [5:0] JX2_GR_DHR = 6'h21;
  localparam logic [5:0] JX2_GR_SP  = 6'h22;
  localparam logic [5:0] JX2_GR_ZZR = 6'h3F;

  // Slots 0..31 are the plain GPRs, followed by DLR, DHR and SP.
  localparam int unsigned   CTX_SLOTS    = 35;
  localparam logic    [5:0] CTX_LAST_IDX = 6'(CTX_SLOTS - 1);

  typedef enum logic [2:0] {
    IDLE,
    SV_RD,
    SV_WR,
    RS_RD,
    RS_WR,
    FIN,
    ERR
  } ctxState_t;

endpackage

// File: rtl/gpr_ctx_slotmap.sv
// Maps a context slot index to the GPR file register ID.
module gpr_ctx_slotmap
  import gpr_ctx_seq_pkg::*;
(
  input  logic [5:0] slotIdx,
  output logic [5:0] slotId
);

  // Out-of-range indices fall back to the null register.
  always_comb begin
    slotId = JX2_GR_ZZR;
    if (slotIdx < 6'd32) begin
      slotId = {1'b0, slotIdx[4:0]};
    end else begin
      case (slotIdx)
        6'd32:   slotId = JX2_GR_DLR;
        6'd33:   slotId = JX2_GR_DHR;
        6'd34:   slotId = JX2_GR_SP;
        default: slotId = JX2_GR_ZZR;
      endcase
    end
  end

endmodule

// File: rtl/gpr_ctx_seq.sv
// GPR context save/restore sequencer: walks the 35-entry slot list and
// moves each register to or from memory at ctxBase + idx*8.
module gpr_ctx_seq
  import gpr_ctx_seq_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        ctxReq,
  input  logic        ctxDir,
  input  logic [47:0] ctxBase,
  output logic        ctxBusy,
  output logic        ctxDone,
  output logic        ctxErr,
  output logic        seqHold,
  output logic [5:0]  seqIdRm,
  input  logic [63:0] seqValRm,
  output logic [5:0]  seqIdRn,
  output logic [63:0] seqValRn,
  output logic        memReq,
  output logic        memWr,
  output logic [47:0] memAddr,
  output logic [63:0] memDataOut,
  input  logic [63:0] memDataIn,
  input  logic        memOk,
  input  logic        memErr
);

  ctxState_t   state, stateNext;
  logic [5:0]  idx, idxNext;
  logic [63:0] dataReg, dataNext;
  logic [47:0] baseReg, baseNext;
  logic [5:0]  slotId;
  logic [47:0] slotAddr;

  gpr_ctx_slotmap uSlotmap (
    .slotIdx (idx),
    .slotId  (slotId)
  );

  // Base is captured at start so the request address stays stable even if
  // ctxBase moves mid-operation; the sum wraps modulo 2^48.
  assign slotAddr = baseReg + {39'd0, idx, 3'b000};

  assign ctxBusy = (state != IDLE);
  assign seqHold = ctxBusy;

  // State, index, data and base registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      idx     <= '0;
      dataReg <= '0;
      baseReg <= '0;
    end else begin
      state   <= stateNext;
      idx     <= idxNext;
      dataReg <= dataNext;
      baseReg <= baseNext;
    end
  end

  // Completion pulses are registered so they appear the cycle after FIN/ERR.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ctxDone <= 1'b0;
      ctxErr  <= 1'b0;
    end else begin
      ctxDone <= (state == FIN);
      ctxErr  <= (state == ERR);
    end
  end

  // Next-state logic and per-state drive of GPR and memory ports.
  always_comb begin
    stateNext  = state;
    idxNext    = idx;
    dataNext   = dataReg;
    baseNext   = baseReg;
    seqIdRm    = JX2_GR_ZZR;
    seqIdRn    = JX2_GR_ZZR;
    seqValRn   = '0;
    memReq     = 1'b0;
    memWr      = 1'b0;
    memAddr    = '0;
    memDataOut = '0;
    case (state)
      IDLE: begin
        if (ctxReq) begin
          if (ctxBase[2:0] != 3'b000) begin
            stateNext = ERR;
          end else begin
            idxNext   = '0;
            baseNext  = ctxBase;
            stateNext = ctxDir ? RS_RD : SV_RD;
          end
        end
      end
      SV_RD: begin
        seqIdRm   = slotId;
        dataNext  = seqValRm;
        stateNext = SV_WR;
      end
      SV_WR: begin
        memReq     = 1'b1;
        memWr      = 1'b1;
        memAddr    = slotAddr;
        memDataOut = dataReg;
        if (memErr) begin
          stateNext = ERR;
        end else if (memOk) begin
          if (idx == CTX_LAST_IDX) begin
            stateNext = FIN;
          end else begin
            idxNext   = idx + 6'd1;
            stateNext = SV_RD;
          end
        end
      end
      RS_RD: begin
        memReq  = 1'b1;
        memAddr = slotAddr;
        if (memErr) begin
          stateNext = ERR;
        end else if (memOk) begin
          dataNext  = memDataIn;
          stateNext = RS_WR;
        end
      end
      RS_WR: begin
        seqIdRn  = slotId;
        seqValRn = dataReg;
        if (idx == CTX_LAST_IDX) begin
          stateNext = FIN;
        end else begin
          idxNext   = idx + 6'd1;
          stateNext = RS_RD;
        end
      end
      FIN:     stateNext = IDLE;
      ERR:     stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

endmodule

// File: tb/tb_gpr_ctx_seq.sv
// Directed bench for gpr_ctx_seq with a GPR file model and a memory model
// offering configurable wait states and error injection.
module tb_gpr_ctx_seq;

  localparam logic [5:0] ID_DLR = 6'h20;
  localparam logic [5:0] ID_DHR = 6'h21;
  localparam logic [5:0] ID_SP  = 6'h22;
  localparam logic [5:0] ID_ZZR = 6'h3F;

  logic        clock;
  logic        reset;
  logic        ctxReq;
  logic        ctxDir;
  logic [47:0] ctxBase;
  logic        ctxBusy;
  logic        ctxDone;
  logic        ctxErr;
  logic        seqHold;
  logic [5:0]  seqIdRm;
  logic [63:0] seqValRm;
  logic [5:0]  seqIdRn;
  logic [63:0] seqValRn;
  logic        memReq;
  logic        memWr;
  logic [47:0] memAddr;
  logic [63:0] memDataOut;
  logic [63:0] memDataIn;
  logic        memOk;
  logic        memErr;

  gpr_ctx_seq dut (
    .clock      (clock),
    .reset      (reset),
    .ctxReq     (ctxReq),
    .ctxDir     (ctxDir),
    .ctxBase    (ctxBase),
    .ctxBusy    (ctxBusy),
    .ctxDone    (ctxDone),
    .ctxErr     (ctxErr),
    .seqHold    (seqHold),
    .seqIdRm    (seqIdRm),
    .seqValRm   (seqValRm),
    .seqIdRn    (seqIdRn),
    .seqValRn   (seqValRn),
    .memReq     (memReq),
    .memWr      (memWr),
    .memAddr    (memAddr),
    .memDataOut (memDataOut),
    .memDataIn  (memDataIn),
    .memOk      (memOk),
    .memErr     (memErr)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // GPR file model: combinational read port, write logged from seqIdRn.
  logic [63:0] gpr [64];
  assign seqValRm = gpr[seqIdRm];

  // Memory model window at 0x4000..0x41FF.
  logic [63:0] mem [64];
  logic [47:0] memOff;
  logic        inRange;
  int          waitStates;
  int          waitCnt;
  logic        errEn;
  logic [47:0] errAddr;

  assign memOff    = memAddr - 48'h4000;
  assign inRange   = (memOff < 48'h200);
  assign memDataIn = inRange ? mem[memOff[8:3]] : 64'hBAD0BAD0BAD0BAD0;
  assign memOk     = memReq && (waitCnt >= waitStates);
  assign memErr    = memOk && errEn && (memAddr == errAddr);

  always @(posedge clock) begin
    if (!memReq || memOk) waitCnt <= 0;
    else                  waitCnt <= waitCnt + 1;
  end

  // Monitor sampled mid-cycle.
  int          doneCount, errCount, reqCycles, busyCycles, holdBad, stabBad;
  logic [47:0] stAddr [$];
  logic [63:0] stData [$];
  logic [5:0]  wrIds  [$];
  logic [63:0] wrVals [$];
  logic        pend;
  logic [47:0] pAddr;
  logic [63:0] pData;
  logic        pWr;

  always @(negedge clock) begin
    if (ctxDone) doneCount++;
    if (ctxErr) errCount++;
    if (memReq) reqCycles++;
    if (ctxBusy) busyCycles++;
    if (seqHold !== ctxBusy) holdBad++;
    if (seqIdRn != ID_ZZR) begin
      wrIds.push_back(seqIdRn);
      wrVals.push_back(seqValRn);
      gpr[seqIdRn] = seqValRn;
    end
    if (memReq && memWr && memOk && !memErr) begin
      stAddr.push_back(memAddr);
      stData.push_back(memDataOut);
      if (inRange) mem[memOff[8:3]] = memDataOut;
    end
    if (reset && pend) begin
      if (!memReq || memAddr != pAddr || memWr != pWr || memDataOut != pData) stabBad++;
    end
    pend  = reset && memReq && !memOk && !memErr;
    pAddr = memAddr;
    pData = memDataOut;
    pWr   = memWr;
  end

  int nChecks = 0;
  int nPass   = 0;

  task automatic checkVal(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nChecks++;
    if (obs === exp) nPass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  function automatic logic [5:0] expId(input int i);
    if (i < 32) return 6'(i);
    if (i == 32) return ID_DLR;
    if (i == 33) return ID_DHR;
    return ID_SP;
  endfunction

  function automatic logic [63:0] expSave(input int i);
    if (i < 32) return 64'h1000 + 64'(i);
    if (i == 32) return 64'hAA;
    if (i == 33) return 64'hBB;
    return 64'hCC;
  endfunction

  task automatic initGpr();
    for (int i = 0; i < 64; i++) gpr[i] = '0;
    for (int i = 0; i < 35; i++) gpr[expId(i)] = expSave(i);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  // Starts an operation from #1 after an edge; lat is the edge count at
  // which ctxDone/ctxErr is first seen, -1 on timeout.
  task automatic runOp(input logic dir, input logic [47:0] base, input bit injectReq,
                       output int lat);
    int cnt;
    cnt     = 0;
    lat     = -1;
    ctxDir  = dir;
    ctxBase = base;
    ctxReq  = 1'b1;
    while (cnt < 400) begin
      @(posedge clock);
      #1;
      cnt++;
      if (cnt == 1) ctxReq = 1'b0;
      if (injectReq && cnt == 20) ctxReq = 1'b1;
      if (injectReq && cnt == 21) ctxReq = 1'b0;
      if (ctxDone || ctxErr) begin
        lat = cnt;
        break;
      end
    end
    ctxReq = 1'b0;
  endtask

  task automatic checkResetOutputs(input string pfx);
    checkVal({pfx, "_busy"}, 64'(ctxBusy), 64'd0);
    checkVal({pfx, "_done"}, 64'(ctxDone), 64'd0);
    checkVal({pfx, "_err"}, 64'(ctxErr), 64'd0);
    checkVal({pfx, "_hold"}, 64'(seqHold), 64'd0);
    checkVal({pfx, "_memReq"}, 64'(memReq), 64'd0);
    checkVal({pfx, "_memWr"}, 64'(memWr), 64'd0);
    checkVal({pfx, "_memAddr"}, 64'(memAddr), 64'd0);
    checkVal({pfx, "_memData"}, memDataOut, 64'd0);
    checkVal({pfx, "_valRn"}, seqValRn, 64'd0);
    checkVal({pfx, "_idRm"}, 64'(seqIdRm), 64'(ID_ZZR));
    checkVal({pfx, "_idRn"}, 64'(seqIdRn), 64'(ID_ZZR));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int lat, d0, e0, r0, w0, b0, cnt;
    bit found;
    reset      = 1'b0;
    ctxReq     = 1'b0;
    ctxDir     = 1'b0;
    ctxBase    = '0;
    waitStates = 0;
    errEn      = 1'b0;
    errAddr    = '0;
    doneCount  = 0;
    errCount   = 0;
    reqCycles  = 0;
    busyCycles = 0;
    holdBad    = 0;
    stabBad    = 0;
    for (int i = 0; i < 64; i++) mem[i] = '0;
    initGpr();

    // Reset state
    repeat (3) @(posedge clock);
    #1;
    checkResetOutputs("rst");
    reset = 1'b1;
    idle(2);

    // Save, zero-wait memory
    d0 = doneCount; b0 = busyCycles;
    stAddr.delete(); stData.delete();
    runOp(1'b0, 48'h4000, 1'b0, lat);
    idle(3);
    checkVal("save_lat", 64'(lat), 64'd72);
    checkVal("save_nstores", 64'(stAddr.size()), 64'd35);
    for (int i = 0; i < 35; i++) begin
      checkVal($sformatf("save_addr%0d", i), 64'(stAddr[i]), 64'h4000 + 64'(i * 8));
      checkVal($sformatf("save_data%0d", i), stData[i], expSave(i));
    end
    checkVal("save_busycyc", 64'(busyCycles - b0), 64'd71);
    checkVal("save_holdbad", 64'(holdBad), 64'd0);
    checkVal("save_donecnt", 64'(doneCount - d0), 64'd1);

    // Misaligned base
    d0 = doneCount; e0 = errCount; r0 = reqCycles; w0 = wrIds.size();
    runOp(1'b0, 48'h4004, 1'b0, lat);
    idle(3);
    checkVal("mis_lat", 64'(lat), 64'd2);
    checkVal("mis_reqcyc", 64'(reqCycles - r0), 64'd0);
    checkVal("mis_gprwr", 64'(wrIds.size() - w0), 64'd0);
    checkVal("mis_errcnt", 64'(errCount - e0), 64'd1);
    checkVal("mis_donecnt", 64'(doneCount - d0), 64'd0);

    // Restore, 2-wait-state memory
    for (int i = 0; i < 35; i++) mem[i] = 64'hDEAD0000 + 64'(i);
    waitStates = 2;
    stabBad = 0; d0 = doneCount;
    wrIds.delete(); wrVals.delete();
    runOp(1'b1, 48'h4000, 1'b0, lat);
    idle(3);
    checkVal("rs_lat", 64'(lat), 64'd142);
    checkVal("rs_nwrites", 64'(wrIds.size()), 64'd35);
    for (int i = 0; i < 35; i++) begin
      checkVal($sformatf("rs_id%0d", i), 64'(wrIds[i]), 64'(expId(i)));
      checkVal($sformatf("rs_val%0d", i), wrVals[i], 64'hDEAD0000 + 64'(i));
    end
    checkVal("rs_donecnt", 64'(doneCount - d0), 64'd1);
    checkVal("rs_stable", 64'(stabBad), 64'd0);

    // Memory error on slot 5 during restore
    waitStates = 0;
    for (int i = 0; i < 64; i++) gpr[i] = 64'h5555;
    wrIds.delete(); wrVals.delete();
    d0 = doneCount; e0 = errCount;
    errEn = 1'b1; errAddr = 48'h4028;
    runOp(1'b1, 48'h4000, 1'b0, lat);
    idle(3);
    errEn = 1'b0;
    checkVal("merr_lat", 64'(lat), 64'd13);
    checkVal("merr_nwrites", 64'(wrIds.size()), 64'd5);
    for (int i = 0; i < 5; i++)
      checkVal($sformatf("merr_id%0d", i), 64'(wrIds[i]), 64'(i));
    checkVal("merr_gpr4", gpr[4], 64'hDEAD0004);
    checkVal("merr_gpr5", gpr[5], 64'h5555);
    checkVal("merr_gpr6", gpr[6], 64'h5555);
    checkVal("merr_errcnt", 64'(errCount - e0), 64'd1);
    checkVal("merr_donecnt", 64'(doneCount - d0), 64'd0);
    checkVal("merr_idle", 64'(ctxBusy), 64'd0);

    // Reset during SV_WR of slot 10, then re-request
    initGpr();
    d0 = doneCount; e0 = errCount;
    ctxDir = 1'b0; ctxBase = 48'h4000; ctxReq = 1'b1;
    found = 1'b0; cnt = 0;
    while (cnt < 100 && !found) begin
      @(posedge clock);
      #1;
      cnt++;
      if (cnt == 1) ctxReq = 1'b0;
      if (memReq && memWr && memAddr == 48'h4050) found = 1'b1;
    end
    checkVal("rr_reach_slot10", 64'(found), 64'd1);
    reset = 1'b0;
    #1;
    checkResetOutputs("rr");
    idle(2);
    reset = 1'b1;
    idle(2);
    checkVal("rr_nodone", 64'(doneCount - d0), 64'd0);
    checkVal("rr_noerr", 64'(errCount - e0), 64'd0);
    d0 = doneCount;
    stAddr.delete(); stData.delete();
    runOp(1'b0, 48'h4000, 1'b1, lat);
    idle(3);
    checkVal("rr_lat", 64'(lat), 64'd72);
    checkVal("rr_nstores", 64'(stAddr.size()), 64'd35);
    checkVal("rr_first", stData[0], 64'h1000);
    checkVal("rr_last_addr", 64'(stAddr[34]), 64'h4110);
    checkVal("rr_last_data", stData[34], 64'hCC);
    checkVal("rr_donecnt", 64'(doneCount - d0), 64'd1);
    r0 = reqCycles;
    idle(5);
    checkVal("rr_noqueue_busy", 64'(ctxBusy), 64'd0);
    checkVal("rr_noqueue_req", 64'(reqCycles - r0), 64'd0);

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
